stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control FSM that sequences the four-digit BCD millisecond counter (digits one/ten/hun/thoud) as a stopwatch. It turns two user button levels into counter enable (Cen) and a clear pulse, and drives the display digits. The display shows either the live count or a frozen lap snapshot. It sits between the button front end, which delivers synchronized and debounced levels, and the counter and display decoder.

## Interface
- HOLD_LAST_LAP, default 0: 1 keeps the lap snapshot on display after PAUSE; 0 returns the display to live on PAUSE.
- msclk  in  1  system clock, 1 kHz tick domain; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_ss  in  1  start/stop button level (already synchronized/debounced).
- btn_lr  in  1  lap/reset button level (already synchronized/debounced).
- one, ten, hun, thoud  in  4 each  live BCD digits from the counter.
- Cen  out  1  counter enable; counter increments on each msclk edge while high.
- clr  out  1  one-cycle clear pulse to the counter.
- disp_one, disp_ten, disp_hun, disp_thoud  out  4 each  digits to the display.
- lap_active  out  1  high while the display is frozen.
- full  out  1  count saturated at 9999 (autostop builds only).

## Operation
- Edge detect: each button has a previous-sample register; a press is btn & ~prev at a rising edge. A held button yields exactly one press.
- States:
  - IDLE: Cen=0; display live.
  - RUN: Cen=1; display live.
  - LAP: Cen=1; display frozen.
  - PAUSE: Cen=0.
  - FULL: Cen=0; full=1; display live.
- Transitions:
  - IDLE: ss press -> RUN; lr press is ignored.
  - RUN: ss press -> PAUSE; lr press -> LAP, latching the live digits into the snapshot on the same edge.
  - LAP: lr press -> RUN, display back to live; ss press -> PAUSE.
  - PAUSE: ss press -> RUN, or -> LAP if the snapshot is held; lr press -> IDLE with clr=1 for that single cycle.
  - FULL: lr press -> IDLE with clr=1; ss press is ignored.
- Display in PAUSE: live, unless HOLD_LAST_LAP=1 and PAUSE was entered from LAP; in that case the snapshot is held and lap_active stays 1.
- Simultaneous ss and lr presses in the same cycle: ss wins and lr is discarded.
- Digit compares are exact BCD equality; the block never performs arithmetic on the digits.

## Timing
- Reset values: state=IDLE, Cen=0, clr=0, lap_active=0, full=0, snapshot=0, prev regs=0, disp_*=live inputs.
- Press latency: a press first sampled at edge k updates state and Cen on edge k. The counter's first increment happens at edge k+1.
- clr is high for exactly one cycle, on the cycle after the transition to IDLE. The counter reads 0000 from the following edge.
- The snapshot is captured at edge k from the digits present before that edge's increment.
- Reset mid-run: Cen drops immediately (asynchronously). The counter value is not this block's concern.

## Configuration
- STOPWATCH_AUTOSTOP_EN defined:
  - In RUN or LAP, when Cen=1 and the digits equal 9998, the next edge moves to FULL and drops Cen, so the counter stops at 9999.
  - A resume from PAUSE with the digits at 9999 goes to FULL instead of RUN.
  - If an ss press coincides with the 9998 condition, the press wins and the state goes to PAUSE.
- Not defined: FULL is unreachable, full is tied to 0, and the counter wraps 9999 -> 0000 with no special action.

## Structure
- stopwatch_pkg holds:
  - the state enum (IDLE, RUN, LAP, PAUSE, FULL), 3-bit;
  - the bcd_t 4-bit typedef;
  - the constants BCD_NINE=4'd9 and BCD_EIGHT=4'd8.
- One sub-module, btn_edge (previous-sample register plus rising-edge pulse), instantiated once per button.

## Test plan
- Reset 100 ns, then ss pulse -> Cen=1 on the same edge; the counter advances 1 per cycle; lap_active=0.
- RUN at count 0123, lr pulse -> disp shows 0123 while the live count keeps advancing; a second lr pulse -> disp returns to live.
- RUN, ss and lr pulsed in the same cycle -> PAUSE, Cen=0, no lap captured, clr stays 0.
- PAUSE at 0456, lr pulse -> clr high for exactly one cycle, state IDLE, counter reads 0000; a following lr pulse is ignored.
- Hold ss high for 50 cycles from IDLE -> exactly one transition to RUN, with no toggling.
- With STOPWATCH_AUTOSTOP_EN, start at 9990 -> count stops at 9999, full=1, ss is ignored, lr clears to 0000 and returns to IDLE; without the macro the count wraps to 0000.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD digit types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LAP   = 3'd2,
        PAUSE = 3'd3,
        FULL  = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t thoud;
        bcd_t hun;
        bcd_t ten;
        bcd_t one;
    } digits_t;

    localparam bcd_t BCD_NINE  = 4'd9;
    localparam bcd_t BCD_EIGHT = 4'd8;

    // True when the upper three digits read 999 and the units digit equals last.
    function automatic logic digits_at_99x(input digits_t d, input bcd_t last);
        return (d.thoud == BCD_NINE) && (d.hun == BCD_NINE) &&
               (d.ten == BCD_NINE) && (d.one == last);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Previous-sample register and single-cycle rising-edge press pulse for one
// already-debounced button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_press
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    // The press is visible in the same cycle the level first reads high.
    assign o_press = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: turns start/stop and lap/reset buttons into counter
// enable and clear, and selects live or lap-frozen digits for the display.
// Optional autostop at 9999 is built when STOPWATCH_AUTOSTOP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit HOLD_LAST_LAP = 1'b0
) (
    input  logic       msclk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] one,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] thoud,
    output logic       Cen,
    output logic       clr,
    output logic [3:0] disp_one,
    output logic [3:0] disp_ten,
    output logic [3:0] disp_hun,
    output logic [3:0] disp_thoud,
    output logic       lap_active,
    output logic       full
);

`ifdef STOPWATCH_AUTOSTOP_EN
    localparam bit AUTOSTOP = 1'b1;
`else
    localparam bit AUTOSTOP = 1'b0;
`endif

    state_t  r_state;
    logic    r_hold;
    logic    r_clr;
    digits_t r_snap;

    state_t  w_next_state;
    logic    w_next_hold;
    logic    w_clr_set;
    logic    w_capture;
    logic    w_ss_press;
    logic    w_lr_press;
    logic    w_ss;
    logic    w_lr;
    logic    w_autostop;
    logic    w_at_max;
    logic    w_cen;
    logic    w_lap;
    logic    w_full;
    digits_t w_live;

    btn_edge u_ss_edge (
        .clk     (msclk),
        .rst     (reset),
        .i_level (btn_ss),
        .o_press (w_ss_press)
    );

    btn_edge u_lr_edge (
        .clk     (msclk),
        .rst     (reset),
        .i_level (btn_lr),
        .o_press (w_lr_press)
    );

    assign w_live = '{thoud: thoud, hun: hun, ten: ten, one: one};

    // A start/stop press always takes precedence over a same-cycle lap/reset press.
    assign w_ss = w_ss_press;
    assign w_lr = w_lr_press & ~w_ss_press;

    assign w_autostop = AUTOSTOP & digits_at_99x(w_live, BCD_EIGHT);
    assign w_at_max   = AUTOSTOP & digits_at_99x(w_live, BCD_NINE);

    always_ff @(posedge msclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_hold  <= w_next_hold;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_hold  = r_hold;
        w_clr_set    = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_ss) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_ss) begin
                    w_next_state = PAUSE;
                end else if (w_autostop) begin
                    w_next_state = FULL;
                end else if (w_lr) begin
                    w_next_state = LAP;
                    w_capture    = 1'b1;
                end
            end
            LAP: begin
                if (w_ss) begin
                    w_next_state = PAUSE;
                    w_next_hold  = HOLD_LAST_LAP;
                end else if (w_autostop) begin
                    w_next_state = FULL;
                end else if (w_lr) begin
                    w_next_state = RUN;
                end
            end
            PAUSE: begin
                if (w_ss) begin
                    w_next_hold = 1'b0;
                    if (w_at_max) begin
                        w_next_state = FULL;
                    end else if (r_hold) begin
                        w_next_state = LAP;
                    end else begin
                        w_next_state = RUN;
                    end
                end else if (w_lr) begin
                    w_next_state = IDLE;
                    w_next_hold  = 1'b0;
                    w_clr_set    = 1'b1;
                end
            end
            FULL: begin
                if (w_lr) begin
                    w_next_state = IDLE;
                    w_clr_set    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_hold  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_cen  = 1'b0;
        w_lap  = 1'b0;
        w_full = 1'b0;
        unique case (r_state)
            RUN:     w_cen = 1'b1;
            LAP: begin
                w_cen = 1'b1;
                w_lap = 1'b1;
            end
            PAUSE:   w_lap = r_hold;
            FULL:    w_full = AUTOSTOP;
            default: w_cen = 1'b0;
        endcase
    end

    // Clear is registered so it lands in the cycle after the move to IDLE.
    always_ff @(posedge msclk or posedge reset) begin
        if (reset) begin
            r_clr  <= 1'b0;
            r_snap <= '0;
        end else begin
            r_clr <= w_clr_set;
            if (w_capture) begin
                r_snap <= w_live;
            end
        end
    end

    assign Cen        = w_cen;
    assign clr        = r_clr;
    assign lap_active = w_lap;
    assign full       = w_full;

    assign {disp_thoud, disp_hun, disp_ten, disp_one} = w_lap ? r_snap : w_live;

endmodule
